// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter
//
// Shares one byte-wide SPI engine between N_REQ requesters, one byte per transaction.
// A round-robin picker chooses the next requester. The FSM then sequences chip select
// through its setup, transfer, hold and gap phases, pulses the engine start and waits
// for completion (bounded by TIMEOUT). The received byte goes back to the winner with a
// one-cycle done pulse.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   req        per-requester request level, held until the matching done bit
//   req_wdata  byte i at [8*i+7:8*i], captured when requester i is granted
//   gnt        one-hot grant, high from grant until done
//   done       one-cycle completion pulse to the granted requester
//   err        one-cycle pulse alongside done when the engine timed out
//   rdata      byte from the engine, held until it is replaced
//   cs_n       active-low chip select to the SPI slave
//   eng_start  one-cycle pulse telling the engine to shift a byte
//   eng_wdata  byte for the engine, stable from eng_start to eng_done
//   eng_done   one-cycle pulse from the engine, eng_rdata valid
//   eng_rdata  byte shifted in by the engine

module spi_xfer_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_GAP   = 1,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               err,
    output logic [7:0]         rdata,
    output logic               cs_n,
    output logic               eng_start,
    output logic [7:0]         eng_wdata,
    input  logic               eng_done,
    input  logic [7:0]         eng_rdata
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SumW = IdxW + 1;

    // One counter serves every timed phase, so size it for the longest one.
    localparam int unsigned Max1   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned Max2   = (Max1 > CS_GAP) ? Max1 : CS_GAP;
    localparam int unsigned MaxCnt = (Max2 > TIMEOUT) ? Max2 : TIMEOUT;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP - 1);
    localparam logic [CntW-1:0] XferLast  = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] HoldLast  = CntW'(CS_HOLD - 1);
    localparam logic [CntW-1:0] GapLast   = CntW'(CS_GAP - 1);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(N_REQ - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StXfer,
        StHold,
        StGap
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [IdxW-1:0] rr_ptr_q;
    logic [IdxW-1:0] winner_q;
    logic            timed_out_q;

    // ------------------------------------------------------------------
    // Round-robin picker: first set request at rr_ptr, rr_ptr+1, ...
    // ------------------------------------------------------------------
    logic            pick_valid;
    logic [IdxW-1:0] pick_idx;
    logic [SumW-1:0] cand;
    logic [7:0]      pick_wdata;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        // Walk offsets from far to near so the nearest requester is written last and wins.
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + SumW'(k);
            if (cand >= SumW'(N_REQ)) begin
                cand = cand - SumW'(N_REQ);
            end
            if (req[cand[IdxW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        pick_wdata = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (pick_idx == IdxW'(i)) begin
                pick_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            winner_q    <= '0;
            timed_out_q <= 1'b0;
            gnt         <= '0;
            done        <= '0;
            err         <= 1'b0;
            rdata       <= '0;
            cs_n        <= 1'b1;
            eng_start   <= 1'b0;
            eng_wdata   <= '0;
        end else begin
            // Pulse outputs default low; the states below raise them for a single cycle.
            eng_start <= 1'b0;
            done      <= '0;
            err       <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        winner_q    <= pick_idx;
                        gnt         <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        eng_wdata   <= pick_wdata;
                        cs_n        <= 1'b0;
                        cnt_q       <= '0;
                        timed_out_q <= 1'b0;
                        state_q     <= StSetup;
                    end
                end

                StSetup: begin
                    if (cnt_q == SetupLast) begin
                        eng_start <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= StXfer;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end

                StXfer: begin
                    // A completion arriving on the last allowed cycle beats the timeout.
                    if (eng_done) begin
                        rdata   <= eng_rdata;
                        cnt_q   <= '0;
                        state_q <= StHold;
                    end else if (cnt_q == XferLast) begin
                        timed_out_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= StHold;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end

                StHold: begin
                    if (cnt_q == HoldLast) begin
                        cs_n     <= 1'b1;
                        gnt      <= '0;
                        done     <= gnt;
                        err      <= timed_out_q;
                        rr_ptr_q <= (winner_q == IdxLast) ? '0 : winner_q + IdxW'(1);
                        cnt_q    <= '0;
                        state_q  <= StGap;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end

                StGap: begin
                    if (cnt_q == GapLast) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_done_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done));
    a_err_with_done: assert property (@(posedge clk) disable iff (!rst_n) err |-> (|done));
    a_cs_with_gnt: assert property (@(posedge clk) disable iff (!rst_n) !cs_n |-> (|gnt));

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter
//
// Randomised and directed bench for spi_xfer_arbiter. The reference model works on a
// transaction timeline: grant edge, start edge, transfer end and done edge are derived
// with plain arithmetic from the guard times, and the winner comes from a round-robin scan.

module tb_spi_xfer_arbiter;

    localparam int N_REQ    = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_GAP   = 1;
    localparam int TIMEOUT  = 64;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic [N_REQ-1:0]   req       = '0;
    logic [8*N_REQ-1:0] req_wdata = '0;
    logic               eng_done  = 1'b0;
    logic [7:0]         eng_rdata = '0;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic               err;
    logic [7:0]         rdata;
    logic               cs_n;
    logic               eng_start;
    logic [7:0]         eng_wdata;

    spi_xfer_arbiter #(
        .N_REQ    (N_REQ),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD),
        .CS_GAP   (CS_GAP),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .cs_n      (cs_n),
        .eng_start (eng_start),
        .eng_wdata (eng_wdata),
        .eng_done  (eng_done),
        .eng_rdata (eng_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state (transaction timeline)
    bit         m_busy     = 1'b0;
    int         m_w        = 0;
    int         m_s        = 0;
    bit         m_res      = 1'b0;
    int         m_xend     = 0;
    bit         m_tmo      = 1'b0;
    int         m_rr       = 0;
    logic [7:0] m_rdata    = '0;
    logic [7:0] m_wdata    = '0;
    int         m_free     = 0;
    bit         m_done_now = 1'b0;
    bit         m_new_gnt  = 1'b0;
    int         m_last_w   = 0;
    int         n_done     = 0;

    // Engine and client stimulus controls
    int               eng_sched     = -1;
    int               eng_mode      = 1;
    int               eng_fixed_k   = 3;
    bit               spurious_en   = 1'b0;
    bit               fixed_rd_en   = 1'b0;
    logic [7:0]       fixed_rd      = '0;
    bit               hold_req      = 1'b0;
    bit               rand_clients  = 1'b0;
    bit               rand_wdata    = 1'b0;
    bit [N_REQ-1:0]   waiting       = '0;

    // Observations of the DUT used by directed checks
    int               dut_glog[$];
    logic [N_REQ-1:0] prev_gnt    = '0;
    int               start_cyc   = -1;
    logic [7:0]       start_wdata = '0;
    int               done_cyc    = -1;
    logic             done_err    = 1'b0;
    logic [N_REQ-1:0] done_vec    = '0;
    int               req_cyc     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [N_REQ-1:0] onehot(input int i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int oh2idx(input logic [N_REQ-1:0] v);
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) return i;
        end
        return 99;
    endfunction

    function automatic int rr_pick(input logic [N_REQ-1:0] r, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            if (r[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic drive_next();
        int r;
        if (m_new_gnt) begin
            if (eng_mode == 1) begin
                eng_sched = m_s + eng_fixed_k;
            end else if (eng_mode == 2) begin
                eng_sched = -1;
            end else begin
                r = int'($urandom_range(0, 9));
                if (r == 0)      eng_sched = -1;
                else if (r == 1) eng_sched = m_s + TIMEOUT;
                else if (r == 2) eng_sched = m_s + TIMEOUT + 1;
                else             eng_sched = m_s + int'($urandom_range(1, 20));
            end
        end
        if (m_busy && !m_res && (cyc + 1 > m_s)) begin
            eng_done = (cyc + 1 == eng_sched);
        end else begin
            eng_done = spurious_en && ($urandom_range(0, 5) == 0);
        end
        eng_rdata = fixed_rd_en ? fixed_rd : 8'($urandom);

        for (int i = 0; i < N_REQ; i++) begin
            if (m_done_now && m_last_w == i) begin
                waiting[i] = 1'b0;
                if (!hold_req) req[i] = 1'b0;
            end
        end
        if (rand_clients) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!waiting[i] && $urandom_range(0, 5) == 0) begin
                    waiting[i] = 1'b1;
                    req[i]     = 1'b1;
                end else if (m_busy && m_w == i && $urandom_range(0, 29) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        if (rand_wdata) begin
            for (int i = 0; i < N_REQ; i++) req_wdata[8*i +: 8] = 8'($urandom);
        end
    endtask

    task automatic step();
        logic [N_REQ-1:0]   r_in;
        logic               rst_in;
        logic               ed_in;
        logic [7:0]         er_in;
        logic [8*N_REQ-1:0] wd_in;
        logic [N_REQ-1:0]   gnt_e;
        logic [N_REQ-1:0]   done_e;
        r_in   = req;
        rst_in = rst_n;
        ed_in  = eng_done;
        er_in  = eng_rdata;
        wd_in  = req_wdata;
        @(posedge clk);
        #1;
        cyc++;

        m_done_now = 1'b0;
        m_new_gnt  = 1'b0;
        if (!rst_in) begin
            m_busy  = 1'b0;
            m_rr    = 0;
            m_rdata = '0;
            m_wdata = '0;
            m_free  = cyc + 1;
        end else begin
            if (m_busy && !m_res && cyc > m_s) begin
                if (ed_in) begin
                    m_res   = 1'b1;
                    m_xend  = cyc;
                    m_tmo   = 1'b0;
                    m_rdata = er_in;
                end else if (cyc == m_s + TIMEOUT) begin
                    m_res  = 1'b1;
                    m_xend = cyc;
                    m_tmo  = 1'b1;
                end
            end
            if (m_busy && m_res && cyc == m_xend + CS_HOLD) begin
                m_done_now = 1'b1;
                m_last_w   = m_w;
                m_rr       = (m_w + 1) % N_REQ;
                m_busy     = 1'b0;
                m_free     = cyc + CS_GAP + 1;
                n_done++;
            end
            if (!m_busy && cyc >= m_free && r_in != '0) begin
                m_w       = rr_pick(r_in, m_rr);
                m_s       = cyc + CS_SETUP;
                m_wdata   = wd_in[8*m_w +: 8];
                m_busy    = 1'b1;
                m_res     = 1'b0;
                m_new_gnt = 1'b1;
            end
        end

        gnt_e  = m_busy ? onehot(m_w) : '0;
        done_e = m_done_now ? onehot(m_last_w) : '0;
        check("gnt", gnt, gnt_e);
        check("cs_n", cs_n, !m_busy);
        check("eng_start", eng_start, m_busy && cyc == m_s);
        check("eng_wdata", eng_wdata, m_wdata);
        check("done", done, done_e);
        check("err", err, m_done_now && m_tmo);
        check("rdata", rdata, m_rdata);

        if (gnt != '0 && prev_gnt == '0) dut_glog.push_back(oh2idx(gnt));
        prev_gnt = gnt;
        if (eng_start) begin
            start_cyc   = cyc;
            start_wdata = eng_wdata;
        end
        if (done != '0) begin
            done_cyc = cyc;
            done_err = err;
            done_vec = done;
        end

        drive_next();
    endtask

    task automatic run_dones(input int n, input int budget);
        int target;
        int b;
        target = n_done + n;
        b      = 0;
        while (n_done < target && b < budget) begin
            step();
            b++;
        end
        if (n_done < target) check("wait_bound", n_done, target);
    endtask

    initial begin
        int fair_exp[5] = '{0, 1, 2, 3, 0};
        int wrap_exp[3] = '{2, 0, 2};
        int b;

        // Reset held three cycles
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_cs_n", cs_n, 1);
        check("rst_gnt", gnt, 0);
        check("rst_start", eng_start, 0);
        check("rst_rdata", rdata, 0);
        rst_n = 1'b1;

        // Fairness: all requesters held continuously
        dut_glog.delete();
        eng_mode    = 1;
        eng_fixed_k = 3;
        hold_req    = 1'b1;
        req         = '1;
        run_dones(5, 400);
        hold_req = 1'b0;
        req      = '0;
        for (int i = 0; i < 5; i++) begin
            check("fair_order", (i < dut_glog.size()) ? dut_glog[i] : 99, fair_exp[i]);
        end
        for (int i = 1; i < dut_glog.size(); i++) begin
            check("fair_repeat", dut_glog[i] == dut_glog[i-1], 0);
        end

        // Wrap: grant 2 moves the pointer to 3, then 0 wins before 2
        step();
        dut_glog.delete();
        req = 4'b0100;
        run_dones(1, 200);
        step();
        req = 4'b0101;
        run_dones(2, 400);
        for (int i = 0; i < 3; i++) begin
            check("wrap_order", (i < dut_glog.size()) ? dut_glog[i] : 99, wrap_exp[i]);
        end

        // Single transaction on requester 1
        step();
        dut_glog.delete();
        fixed_rd_en         = 1'b1;
        fixed_rd            = 8'h3C;
        eng_fixed_k         = 18;
        req_wdata[15:8]     = 8'hA5;
        req                 = 4'b0010;
        req_cyc             = cyc;
        start_cyc           = -1;
        run_dones(1, 200);
        check("single_gnt", (dut_glog.size() > 0) ? dut_glog[0] : 99, 1);
        check("single_lat", start_cyc - req_cyc, 1 + CS_SETUP);
        check("single_wdata", start_wdata, 8'hA5);
        check("single_done", done_vec, 4'b0010);
        check("single_rdata", rdata, 8'h3C);
        check("single_err", done_err, 0);

        // Timeout: engine never answers
        step();
        fixed_rd_en = 1'b0;
        eng_mode    = 2;
        req         = 4'b0010;
        req_cyc     = cyc;
        run_dones(1, 200);
        check("tmo_lat", done_cyc - req_cyc, 1 + CS_SETUP + TIMEOUT + CS_HOLD);
        check("tmo_err", done_err, 1);
        check("tmo_rdata", rdata, 8'h3C);
        check("tmo_cs_n", cs_n, 1);

        // Reset in the middle of a transfer
        step();
        req = 4'b0100;
        b   = 0;
        while (!(m_busy && cyc > m_s + 3) && b < 100) begin
            step();
            b++;
        end
        if (b >= 100) check("reach_xfer", b, 0);
        eng_mode    = 1;
        eng_fixed_k = 5;
        rst_n       = 1'b0;
        req         = '1;
        waiting     = '0;
        dut_glog.delete();
        step();
        rst_n = 1'b1;
        check("rst_mid_cs_n", cs_n, 1);
        check("rst_mid_gnt", gnt, 0);
        check("rst_mid_rdata", rdata, 0);
        run_dones(4, 600);
        check("rst_mid_first", (dut_glog.size() > 0) ? dut_glog[0] : 99, 0);

        // Randomised traffic with spurious engine pulses and occasional resets
        req          = '0;
        waiting      = '0;
        rand_clients = 1'b1;
        rand_wdata   = 1'b1;
        spurious_en  = 1'b1;
        eng_mode     = 0;
        repeat (5000) begin
            step();
            if ($urandom_range(0, 1499) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
        end
        rand_clients = 1'b0;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
